// File: rtl/pool_window_buffer.sv
// pool_window_buffer
// Turns a raster-order feature-map stream (one pixel per cycle, all channels
// in parallel) into non-overlapping 2x2 windows (stride 2) for the average
// pooling stage. Each even row is kept in a line buffer. On odd rows the left
// pixel of each pair is held in a register. The right pixel of the pair
// completes the window, which appears one cycle later. No backpressure.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high
//   sof          start of frame; realigns the column/row counters
//   pix_valid    pix_in carries a pixel this cycle
//   pix_in       one pixel, FM_DEPTH channels of DATA_W bits
//   window_valid 1-cycle pulse, window_out holds a new window
//   window_out   per channel: [0]=top-left [1]=top-right [2]=bottom-left [3]=bottom-right
//   frame_done   1-cycle pulse alongside the last window of a frame
//   col_idx      column of the next expected pixel
//   row_idx      row of the next expected pixel
module pool_window_buffer #(
    parameter int FM_DEPTH  = 64,
    parameter int FM_WIDTH  = 32,
    parameter int FM_HEIGHT = 32,
    parameter int DATA_W    = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     sof,
    input  logic                                     pix_valid,
    input  logic [FM_DEPTH-1:0][DATA_W-1:0]          pix_in,
    output logic                                     window_valid,
    output logic [FM_DEPTH-1:0][3:0][DATA_W-1:0]     window_out,
    output logic                                     frame_done,
    output logic [$clog2(FM_WIDTH)-1:0]              col_idx,
    output logic [$clog2(FM_HEIGHT)-1:0]             row_idx
);

    localparam int CW = $clog2(FM_WIDTH);
    localparam int RW = $clog2(FM_HEIGHT);

    typedef logic [FM_DEPTH-1:0][DATA_W-1:0] pixel_t;

    pixel_t          line_buf [FM_WIDTH];
    pixel_t          left_q;

    logic [CW-1:0]   col_eff;
    logic [RW-1:0]   row_eff;
    logic [CW-1:0]   col_nxt;
    logic [RW-1:0]   row_nxt;
    logic [CW-1:0]   col_m1;
    logic            last_col;
    logic            last_row;
    logic            emit;

    // sof makes the current pixel (0,0); any half-built window is dropped
    // because the effective row becomes even.
    always_comb begin
        col_eff  = sof ? '0 : col_idx;
        row_eff  = sof ? '0 : row_idx;
        last_col = (col_eff == CW'(FM_WIDTH - 1));
        last_row = (row_eff == RW'(FM_HEIGHT - 1));
        col_nxt  = last_col ? '0 : col_eff + CW'(1);
        row_nxt  = row_eff;
        if (last_col) begin
            row_nxt = last_row ? '0 : row_eff + RW'(1);
        end
        col_m1   = col_eff - CW'(1);
        emit     = pix_valid & row_eff[0] & col_eff[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_idx <= '0;
            row_idx <= '0;
        end else if (pix_valid) begin
            col_idx <= col_nxt;
            row_idx <= row_nxt;
        end else if (sof) begin
            col_idx <= '0;
            row_idx <= '0;
        end
    end

    // Line buffer is always written on an even row before it is read on the
    // following odd row, so it needs no reset.
    always_ff @(posedge clk) begin
        if (pix_valid && !row_eff[0]) begin
            line_buf[col_eff] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_q <= '0;
        end else if (pix_valid && row_eff[0] && !col_eff[0]) begin
            left_q <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            window_out   <= '0;
        end else begin
            window_valid <= emit;
            frame_done   <= emit & last_col & last_row;
            if (emit) begin
                for (int c = 0; c < FM_DEPTH; c++) begin
                    window_out[c][0] <= line_buf[col_m1][c];
                    window_out[c][1] <= line_buf[col_eff][c];
                    window_out[c][2] <= left_q[c];
                    window_out[c][3] <= pix_in[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Testbench for pool_window_buffer: 2 channels, 4x4 frames.
// Pixel value = ch*256 + row*16 + col. The driver pushes expected windows into
// a queue and a negedge monitor pops and compares them whenever window_valid
// is seen.
module tb_pool_window_buffer;

    localparam int D  = 2;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 16;

    typedef logic [D-1:0][3:0][DW-1:0] win_t;
    typedef struct {
        win_t w;
        bit   fd;
        int   cyc;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      sof;
    logic                      pix_valid;
    logic [D-1:0][DW-1:0]      pix_in;
    logic                      window_valid;
    win_t                      window_out;
    logic                      frame_done;
    logic [1:0]                col_idx;
    logic [1:0]                row_idx;

    exp_t q[$];
    win_t last_exp = '0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   fd_seen = 0;
    int   fd_expected = 0;

    pool_window_buffer #(
        .FM_DEPTH (D),
        .FM_WIDTH (W),
        .FM_HEIGHT(H),
        .DATA_W   (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sof         (sof),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .window_valid(window_valid),
        .window_out  (window_out),
        .frame_done  (frame_done),
        .col_idx     (col_idx),
        .row_idx     (row_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pv(input int ch, input int r, input int c);
        return DW'(ch * 256 + r * 16 + c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle. A valid pixel at odd row / odd column (without sof)
    // completes a window due one cycle after it is sampled.
    task automatic send(input bit v, input bit s, input int r, input int c);
        exp_t e;
        pix_valid = v;
        sof       = s;
        for (int ch = 0; ch < D; ch++) pix_in[ch] = pv(ch, r, c);
        if (v && !s && (r % 2 == 1) && (c % 2 == 1)) begin
            for (int ch = 0; ch < D; ch++) begin
                e.w[ch][0] = pv(ch, r - 1, c - 1);
                e.w[ch][1] = pv(ch, r - 1, c);
                e.w[ch][2] = pv(ch, r, c - 1);
                e.w[ch][3] = pv(ch, r, c);
            end
            e.fd  = (r == H - 1) && (c == W - 1);
            e.cyc = cyc + 1;
            if (e.fd) fd_expected++;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic full_frame(input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(1'b1, 1'b0, r, c);
                if (gaps) send(1'b0, 1'b0, r, c);
            end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (frame_done) fd_seen++;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_window due_cycle=%0d now=%0d", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (window_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_window actual=%h frame_done=%0b cycle=%0d",
                         window_out, frame_done, cyc);
            end else begin
                e = q.pop_front();
                if (window_out !== e.w || frame_done !== e.fd || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL window actual=%h fd=%0b cyc=%0d expected=%h fd=%0b cyc=%0d",
                             window_out, frame_done, cyc, e.w, e.fd, e.cyc);
                end
                last_exp = e.w;
            end
        end else begin
            checks++;
            if (frame_done !== 1'b0 || window_out !== last_exp) begin
                failures++;
                $display("FAIL hold actual=%h frame_done=%0b expected=%h frame_done=0",
                         window_out, frame_done, last_exp);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        sof       = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(window_valid), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_col", 32'(col_idx), 32'd0);
        chk("reset_row", 32'(row_idx), 32'd0);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 1'b0, 0, 0);
            chk("idle_col", 32'(col_idx), 32'd0);
            chk("idle_row", 32'(row_idx), 32'd0);
        end

        // Contiguous frame
        full_frame(1'b0);
        chk("s1_col_wrap", 32'(col_idx), 32'd0);
        chk("s1_row_wrap", 32'(row_idx), 32'd0);

        // Gapped frame
        full_frame(1'b1);

        // Two back-to-back frames
        full_frame(1'b0);
        full_frame(1'b0);

        // sof where pixel (1,1) would be; partial window is discarded
        for (int c = 0; c < W; c++) send(1'b1, 1'b0, 0, c);
        send(1'b1, 1'b0, 1, 0);
        send(1'b1, 1'b1, 0, 0);
        chk("s4_sof_col", 32'(col_idx), 32'd1);
        chk("s4_sof_row", 32'(row_idx), 32'd0);
        for (int i = 1; i < W * H; i++) send(1'b1, 1'b0, i / W, i % W);

        // sof without a pixel clears the counters
        send(1'b1, 1'b0, 0, 0);
        send(1'b1, 1'b0, 0, 1);
        chk("pre_sof_col", 32'(col_idx), 32'd2);
        send(1'b0, 1'b1, 0, 0);
        chk("sof_idle_col", 32'(col_idx), 32'd0);
        chk("sof_idle_row", 32'(row_idx), 32'd0);
        sof = 1'b0;

        // Asynchronous reset while pixel (1,0) is presented
        for (int c = 0; c < W; c++) send(1'b1, 1'b0, 0, c);
        pix_valid = 1'b1;
        for (int ch = 0; ch < D; ch++) pix_in[ch] = pv(ch, 1, 0);
        #1;
        rst      = 1'b1;
        last_exp = '0;
        #1;
        chk("rst_valid", 32'(window_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_col", 32'(col_idx), 32'd0);
        chk("rst_row", 32'(row_idx), 32'd0);
        checks++;
        if (window_out !== '0) begin
            failures++;
            $display("FAIL rst_window_out actual=%h expected=0", window_out);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pix_valid = 1'b0;
        send(1'b0, 1'b0, 0, 0);
        full_frame(1'b0);

        repeat (4) send(1'b0, 1'b0, 0, 0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("frame_done_count", 32'(fd_seen), 32'(fd_expected));
        chk("frame_done_total", 32'(fd_seen), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_window_buffer.md
Name: pool_window_buffer

Overview:
- Upstream neighbour of the 2x2 average-pooling stage.
- Accepts a raster-order feature-map stream, one pixel per cycle, with all FM_DEPTH channels in parallel.
- Buffers one even row in a line buffer and emits each non-overlapping 2x2 window (stride 2), with a single-cycle valid, in the channel-by-4 layout the pooling stage consumes.
- Has no backpressure; the downstream stage always accepts.

Parameters:
FM_DEPTH, 64, number of channels per pixel
FM_WIDTH, 32, pixels per row; must be even, >=2
FM_HEIGHT, 32, rows per frame; must be even, >=2
DATA_W, 16, bits per channel sample

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
sof  input  1  start of frame; realigns counters
pix_valid  input  1  pix_in carries a valid pixel this cycle
pix_in  input  [FM_DEPTH-1:0][DATA_W-1:0]  one pixel, all channels
window_valid  output  1  window_out is a new window (1-cycle pulse)
window_out  output  [FM_DEPTH-1:0][3:0][DATA_W-1:0]  per channel: [0]=top-left, [1]=top-right, [2]=bottom-left, [3]=bottom-right
frame_done  output  1  1-cycle pulse: last window of frame emitted
col_idx  output  clog2(FM_WIDTH)  column of the next expected pixel
row_idx  output  clog2(FM_HEIGHT)  row of the next expected pixel

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values:
  - window_valid=0, frame_done=0, window_out=0, col_idx=0, row_idx=0.
  - Left-pixel register cleared.
  - Line-buffer contents don't-care (never read before being written).
- Counters:
  - col/row advance only on pix_valid=1.
  - col wraps FM_WIDTH-1 -> 0 and increments row.
  - row wraps FM_HEIGHT-1 -> 0.
  - Idle cycles (pix_valid=0) hold all state and outputs except the pulses, which drop to 0.
- Even row (row[0]=0): the accepted pixel is written to line buffer entry [col]. No output.
- Odd row, even col: the accepted pixel is stored in the left-pixel register. No output.
- Odd row, odd col:
  - Next cycle: window_valid=1, with window_out[c] = {lb[col-1][c], lb[col][c], left[c], pix_in[c]}.
  - Latency is 1 cycle from acceptance of the bottom-right pixel.
- window_out holds its last value while window_valid=0.
- frame_done=1 in the same cycle as the window_valid produced by pixel (FM_HEIGHT-1, FM_WIDTH-1).
- Windows per frame: (FM_WIDTH/2)*(FM_HEIGHT/2).
- sof:
  - sof=1 with pix_valid=1: the pixel is treated as (0,0); counters become col=1, row=0.
  - sof=1 with pix_valid=0: counters clear to 0.
  - A partial window in progress is discarded (no valid emitted). Pulses registered the previous cycle still appear.
- Reset mid-frame: outputs clear immediately (async). No pending window is emitted after deassertion.
- Arithmetic: pure data movement, no width change. Samples are passed bit-exact.

Test Plan:
Config for all scenarios: FM_DEPTH=2, FM_WIDTH=4, FM_HEIGHT=4; pixel value = ch*256 + row*16 + col.

1. Contiguous frame, pix_valid=1 for 16 cycles:
   - 4 window_valid pulses, 1 cycle after pixels 5, 7, 13 and 15.
   - First window ch0 = {0x00,0x01,0x10,0x11}; ch1 = {0x100,0x101,0x110,0x111}.
   - frame_done coincides with the 4th pulse, whose ch0 = {0x22,0x23,0x32,0x33}.
2. Same frame with pix_valid toggling 1,0,1,0:
   - Identical window values and count.
   - Each pulse 1 cycle after its bottom-right pixel; window_out is stable in the gaps.
3. Two back-to-back frames, no sof:
   - 8 windows and 2 frame_done pulses.
   - Frame-2 first window equals frame-1 first window.
4. sof with pix_valid at pixel (1,1) of a frame in progress:
   - No window emitted for that cycle; counters become col=1, row=0.
   - Subsequent full frame yields the correct 4 windows.
5. rst asserted at pixel (1,0):
   - All outputs 0 within the reset cycle; no window is emitted.
   - After release, a fresh frame behaves as scenario 1.
6. Idle after reset, 20 cycles with pix_valid=0:
   - window_valid and frame_done remain 0; col_idx and row_idx remain 0.
